// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared funct3 codes, FSM state type and error decode for dmem_responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_FUNCT3    = 3'd1,
        ERR_STORE_UNS = 3'd2,
        ERR_RANGE     = 3'd3,
        ERR_ALIGN     = 3'd4
    } err_reason_t;

    // First matching reason wins; any reason other than ERR_NONE blocks the access.
    function automatic err_reason_t err_decode(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] byte_off,
        input logic       in_range,
        input logic       align_en
    );
        err_reason_t reason;
        reason = ERR_NONE;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
            reason = ERR_FUNCT3;
        end else if (we && (funct3 == F3_BU || funct3 == F3_HU)) begin
            reason = ERR_STORE_UNS;
        end else if (!in_range) begin
            reason = ERR_RANGE;
        end else if (align_en) begin
            if ((funct3 == F3_H || funct3 == F3_HU) && byte_off[0]) begin
                reason = ERR_ALIGN;
            end else if (funct3 == F3_W && byte_off != 2'b00) begin
                reason = ERR_ALIGN;
            end
        end
        return reason;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_fmt.sv
`default_nettype none
// ============================================================================
// Module   : dmem_load_fmt
// Brief    : Selects the addressed byte/half of a memory word and extends it.
// Revision : 1.0
// ============================================================================
module dmem_load_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[8*byte_off +: 8];
        w_half = byte_off[1] ? word[31:16] : word[15:0];
        result = 32'd0;
        case (funct3)
            F3_B:    result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   result = {24'd0, w_byte};
            F3_H:    result = {{16{w_half[15]}}, w_half};
            F3_HU:   result = {16'd0, w_half};
            F3_W:    result = word;
            default: result = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Stallable data-memory responder with wait states and lane stores.
//            Define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_bypass;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [2:0]    w_f3;
    logic          w_in_range;
    err_reason_t   w_reason;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wr_data;

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge itself,
    // so the operands come straight from the request port.
    assign w_bypass = (r_state == ST_IDLE);
    assign w_we     = w_bypass ? req_we     : r_we;
    assign w_addr   = w_bypass ? req_addr   : r_addr;
    assign w_wdata  = w_bypass ? req_wdata  : r_wdata;
    assign w_f3     = w_bypass ? req_funct3 : r_f3;
    assign w_commit = !reset && (w_next == ST_RESP) && (r_state != ST_RESP);

    assign w_in_range = ({2'b00, w_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_reason   = err_decode(w_we, w_f3, w_addr[1:0], w_in_range, ALIGN_EN);
    assign w_err      = (w_reason != ERR_NONE);
    assign w_idx      = w_addr[AW+1:2];
    assign w_rd_word  = w_in_range ? mem[w_idx] : 32'd0;

    dmem_load_fmt u_load_fmt (
        .word     (w_rd_word),
        .byte_off (w_addr[1:0]),
        .funct3   (w_f3),
        .result   (w_load)
    );

    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = w_wdata;
        case (w_f3)
            F3_B: begin
                w_be      = 4'b0001 << w_addr[1:0];
                w_wr_data = {4{w_wdata[7:0]}};
            end
            F3_H: begin
                w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{w_wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_f3    <= 3'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_f3    <= req_funct3;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
                r_err   <= w_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed plus random checks of dmem_responder against a byte-level model.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int WS = 1;
    localparam int DW = 1024;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [0:4*DW-1];

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference: size from funct3, address aligned down to size.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic err, output logic [31:0] rd);
        int unsigned sz;
        int unsigned base;
        logic [31:0] v;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2])
              || ((a >> 2) >= 32'(DW)) || (ALIGN && (a % sz != 0));
        rd = 32'd0;
        if (!err) begin
            base = a - (a % sz);
            if (we) begin
                for (int i = 0; i < int'(sz); i++) mb[base + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mb[base + i];
                if (!f3[2] && sz == 1 && v[7])  v[31:8]  = '1;
                if (!f3[2] && sz == 2 && v[15]) v[31:16] = '1;
                rd = v;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold,
                        output logic [31:0] got_rd, output logic got_err);
        int n;
        logic        exp_err;
        logic [31:0] exp_rd;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
        check("latency", n, WS);
        model(we, a, wd, f3, exp_err, exp_rd);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        check("rsp_rdata", rsp_rdata, exp_rd);
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd0;
            req_wdata = 32'hFFFF_FFFF; req_funct3 = 3'b010;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("hold_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_rdata", rsp_rdata, exp_rd);
                check("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
                check("hold_ready", {31'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ra;
        logic [2:0]  rf;
        int          n;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_funct3 = 3'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        #1;
        check("after_reset_ready", {31'd0, req_ready}, 32'd1);

        for (int w = 0; w < 64; w++) xact(1'b1, 32'(4 * w), $urandom, 3'b010, 0, rd, er);

        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, rd, er);
        check("sw_err", {31'd0, er}, 32'd0);
        xact(1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);
        xact(1'b1, 32'h11, 32'h0000_005A, 3'b000, 0, rd, er);
        xact(1'b0, 32'h11, 32'd0, 3'b000, 0, rd, er);
        check("lb_5a", rd, 32'h0000_005A);
        xact(1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er);
        check("lw_merged", rd, 32'hDEAD_5AEF);
        xact(1'b1, 32'h12, 32'h0000_8001, 3'b001, 0, rd, er);
        xact(1'b0, 32'h12, 32'd0, 3'b001, 0, rd, er);
        check("lh_sext", rd, 32'hFFFF_8001);
        xact(1'b0, 32'h12, 32'd0, 3'b101, 0, rd, er);
        check("lhu_zext", rd, 32'h0000_8001);

        xact(1'b0, 32'h13, 32'd0, 3'b010, 0, rd, er);
        check("lw_misaligned_err", {31'd0, er}, {31'd0, ALIGN});
        check("lw_misaligned_rdata", rd, ALIGN ? 32'd0 : 32'h8001_5AEF);

        xact(1'b1, 32'(4 * DW), 32'h1111_1111, 3'b010, 0, rd, er);
        check("range_err", {31'd0, er}, 32'd1);
        xact(1'b1, 32'h0, 32'h2222_2222, 3'b011, 0, rd, er);
        check("funct3_err", {31'd0, er}, 32'd1);
        xact(1'b1, 32'h0, 32'h3333_3333, 3'b100, 0, rd, er);
        check("store_bu_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h0, 32'd0, 3'b010, 0, rd, er);

        xact(1'b0, 32'h10, 32'd0, 3'b010, 5, rd, er);
        xact(1'b0, 32'h0, 32'd0, 3'b010, 0, rd, er);

        // Reset lands on the edge that would have committed the store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h1234_5678; req_funct3 = 3'b010;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        check("midreset_wait_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("midreset_valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("midreset_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, 32'h20, 32'd0, 3'b010, 0, rd, er);

        for (int t = 0; t < 200; t++) begin
            n  = int'($urandom % 16);
            ra = (n == 0) ? 32'(4 * DW) + ($urandom % 32'h1000_0000) : ($urandom % 256);
            rf = 3'($urandom % 8);
            xact(1'($urandom % 2), ra, $urandom, rf, (t % 50 == 7) ? 3 : 0, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's load/store port: accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, performs byte/half/word stores with lane enables, and returns sign- or zero-extended load data with an error flag. It sits on the far side of the core's memory address / write-data / read-data interface, replacing the zero-latency memory with a stallable responder.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; valid word index range is 0..DEPTH_WORDS-1.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response; 0..15 legal.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester accepts response.
- `rsp_rdata`  out  32  formatted load data; 0 for stores and errors.
- `rsp_err`  out  1  request was illegal; no memory side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, capture we/addr/wdata/funct3; go WAIT if WAIT_STATES>0, else RESP.
- WAIT: down-counter loaded with WAIT_STATES-1 on acceptance; go RESP when counter is 0.
- Memory access (read and write commit) happens on the transition into RESP; response registers load on the same edge.
- RESP: `rsp_valid`=1, outputs held stable until `rsp_valid && rsp_ready`; then IDLE. No new request accepted in WAIT or RESP.
- Loads: word read at index addr[31:2]; B/BU select byte addr[1:0], H/HU select half addr[1]; B/H sign-extend, BU/HU zero-extend.
- Stores: funct3 000 writes one lane addr[1:0] with wdata[7:0]; 001 writes lanes at addr[1] with wdata[15:0]; 010 writes all four lanes. Other lanes unchanged.
- Errors (`rsp_err`=1, `rsp_rdata`=0, no write): funct3 in {011,110,111}; store with funct3 100/101; addr[31:2] ≥ DEPTH_WORDS; misalignment (see Configuration).

## Timing
- Reset values: `req_ready`=0 while `reset` high, 1 in first cycle after; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; state IDLE, counter 0.
- Latency: request accepted at edge N → `rsp_valid` high in cycle N+1+WAIT_STATES.
- Throughput: at most one request per 2+WAIT_STATES cycles (response handshake cycle, then IDLE cycle).
- `rsp_ready` held low: response persists indefinitely, no change to any output.
- Reset mid-operation (WAIT or RESP): captured request dropped; uncommitted write never occurs; memory contents not cleared.
- Write committed in RESP entry is visible to any subsequent load.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: half at odd address or word with addr[1:0]≠0 → `rsp_err`=1, no access.
- Undefined: no misalignment checking; word ignores addr[1:0], half ignores addr[0] (accesses aligned down); only funct3 and range errors remain.

## Structure
- Package `dmem_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, error-reason decode function.
- Sub-module `dmem_load_fmt`: combinational lane select plus sign/zero extension (word, addr[1:0], funct3 → 32-bit result).
- Storage array, FSM, counter and lane-enable write in the top module.

## Test plan
- Store W 0xDEADBEEF @0x10, WAIT_STATES=1 → `rsp_valid` 2 cycles after accept, err=0; load W @0x10 → 0xDEADBEEF.
- After above: SB 0x5A @0x11, then LB @0x11 → 0x0000005A, LW @0x10 → 0xDEAD5AEF; SH 0x8001 @0x12, LH @0x12 → 0xFFFF8001, LHU → 0x00008001.
- LW @0x13: with `DMEM_ALIGN_CHECK_EN` → err=1, rdata 0; without → returns word @0x10.
- Store @ 4*DEPTH_WORDS or funct3=011 → err=1; follow-up load of word 0 unchanged.
- Hold `rsp_ready`=0 for 5 cycles during RESP → outputs stable, `req_ready`=0, second `req_valid` ignored until handshake.
- Assert `reset` while in WAIT of a SW 0x12345678 @0x20 → no response, `rsp_valid`=0; later LW @0x20 returns prior contents.
